// File: rtl/microsequencer.sv
// rtl/microsequencer.sv - microcode sequencer: IR, T-state counter, fetch words and overrun flag
// uinstr is combinational so a new word appears in the same cycle that tstate changes.
module microsequencer #(
    parameter logic [15:0] FETCH0 = 16'h8060,
    parameter logic [15:0] FETCH1 = 16'hB440,
    parameter logic [15:0] NOP    = 16'h8000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bus_in,
    input  logic        II,
    input  logic        RT,
    input  logic        stall,
    input  logic [15:0] rom_data,
    output logic [10:0] rom_addr,
    output logic [15:0] uinstr,
    output logic [2:0]  tstate,
    output logic        fetching,
    output logic        overrun
);

    logic [15:0] ir_q, ir_d;
    logic [2:0]  tstate_q, tstate_d;
    logic        overrun_q, overrun_d;

    // Stall freezes everything; II and RT are independent of each other.
    always_comb begin
        ir_d      = ir_q;
        tstate_d  = tstate_q;
        overrun_d = overrun_q;
        if (!stall) begin
            if (II) begin
                ir_d = bus_in;
            end
            if (RT) begin
                tstate_d = 3'd0;
            end else begin
                tstate_d = tstate_q + 3'd1;
                if (tstate_q == 3'd7) begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q      <= 16'h0000;
            tstate_q  <= 3'd0;
            overrun_q <= 1'b0;
        end else begin
            ir_q      <= ir_d;
            tstate_q  <= tstate_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        uinstr = rom_data;
        if (reset) begin
            uinstr = NOP;
        end else if (tstate_q == 3'd0) begin
            uinstr = FETCH0;
        end else if (tstate_q == 3'd1) begin
            uinstr = FETCH1;
        end
    end

    assign rom_addr = {ir_q[15:8], tstate_q};
    assign tstate   = tstate_q;
    assign fetching = (tstate_q == 3'd0) || (tstate_q == 3'd1);
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_microsequencer.sv
// tb/tb_microsequencer.sv - directed scoreboard bench for microsequencer
module tb_microsequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bus_in;
    logic        II;
    logic        RT;
    logic        stall;
    logic [15:0] rom_data;
    logic [10:0] rom_addr;
    logic [15:0] uinstr;
    logic [2:0]  tstate;
    logic        fetching;
    logic        overrun;

    microsequencer dut (
        .clk      (clk),
        .reset    (reset),
        .bus_in   (bus_in),
        .II       (II),
        .RT       (RT),
        .stall    (stall),
        .rom_data (rom_data),
        .rom_addr (rom_addr),
        .uinstr   (uinstr),
        .tstate   (tstate),
        .fetching (fetching),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    typedef enum logic [2:0] {S_UINSTR, S_TSTATE, S_ADDR, S_OVR, S_FETCH} sel_t;
    typedef struct {
        string       tag;
        sel_t        sel;
        logic [15:0] val;
    } exp_t;

    exp_t queue_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [15:0] observe(sel_t s);
        case (s)
            S_UINSTR: return uinstr;
            S_TSTATE: return {13'd0, tstate};
            S_ADDR:   return {5'd0, rom_addr};
            S_OVR:    return {15'd0, overrun};
            default:  return {15'd0, fetching};
        endcase
    endfunction

    task automatic push(input string tag, input sel_t s, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = s;
        e.val = v;
        queue_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [15:0] obs;
        #1;
        while (queue_q.size() > 0) begin
            e   = queue_q.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; II = 1'b0; RT = 1'b0;
        bus_in = 16'h0000; rom_data = 16'h0F0F;
        step(); step();
        push("rst_uinstr", S_UINSTR, 16'h8000);
        push("rst_tstate", S_TSTATE, 16'd0);
        push("rst_addr",   S_ADDR,   16'h000);
        push("rst_ovr",    S_OVR,    16'd0);
        push("rst_fetch",  S_FETCH,  16'd1);
        drain();

        reset = 1'b0;
        push("t0_uinstr", S_UINSTR, 16'h8060);
        drain();
        step();
        push("t1_tstate", S_TSTATE, 16'd1);
        push("t1_uinstr", S_UINSTR, 16'hB440);
        push("t1_fetch",  S_FETCH,  16'd1);
        drain();

        II = 1'b1; bus_in = 16'h1234;
        step();
        II = 1'b0; bus_in = 16'h0000; rom_data = 16'hABCD;
        push("t2_tstate", S_TSTATE, 16'd2);
        push("t2_addr",   S_ADDR,   16'h092);
        push("t2_uinstr", S_UINSTR, 16'hABCD);
        push("t2_fetch",  S_FETCH,  16'd0);
        drain();

        step();
        stall = 1'b1; II = 1'b1; RT = 1'b1; bus_in = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            push("stall_tstate", S_TSTATE, 16'd3);
            push("stall_addr",   S_ADDR,   16'h093);
            drain();
        end
        stall = 1'b0; II = 1'b0; RT = 1'b0; bus_in = 16'h0000;
        step();
        push("resume_tstate", S_TSTATE, 16'd4);
        push("resume_addr",   S_ADDR,   16'h094);
        drain();

        RT = 1'b1;
        step();
        push("rt_tstate", S_TSTATE, 16'd0);
        push("rt_uinstr", S_UINSTR, 16'h8060);
        push("rt_ovr",    S_OVR,    16'd0);
        drain();

        step();
        RT = 1'b0;
        push("rt_t0_tstate", S_TSTATE, 16'd0);
        push("rt_t0_ovr",    S_OVR,    16'd0);
        drain();

        for (int i = 0; i < 7; i++) step();
        rom_data = 16'h5A5A;
        push("t7_tstate", S_TSTATE, 16'd7);
        push("t7_ovr",    S_OVR,    16'd0);
        push("t7_uinstr", S_UINSTR, 16'h5A5A);
        drain();
        step();
        push("wrap_tstate", S_TSTATE, 16'd0);
        push("wrap_ovr",    S_OVR,    16'd1);
        drain();

        RT = 1'b1;
        step(); step();
        RT = 1'b0;
        push("sticky_ovr",    S_OVR,    16'd1);
        push("sticky_tstate", S_TSTATE, 16'd0);
        drain();

        for (int i = 0; i < 5; i++) step();
        push("t5_tstate", S_TSTATE, 16'd5);
        drain();

        reset = 1'b1; stall = 1'b1; II = 1'b1; bus_in = 16'h5555;
        push("rst_mid_uinstr", S_UINSTR, 16'h8000);
        drain();
        step();
        push("rst_mid_tstate", S_TSTATE, 16'd0);
        push("rst_mid_addr",   S_ADDR,   16'h000);
        push("rst_mid_ovr",    S_OVR,    16'd0);
        push("rst_mid_fetch",  S_FETCH,  16'd1);
        drain();

        reset = 1'b0; stall = 1'b0; II = 1'b0; bus_in = 16'h0000;
        push("post_rst_uinstr", S_UINSTR, 16'h8060);
        drain();
        step();
        push("post_rst_tstate", S_TSTATE, 16'd1);
        push("post_rst_addr",   S_ADDR,   16'h001);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/microsequencer.md
MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 The block SHALL have the following ports, one per line: name, direction, width, meaning (clock and reset first).
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- bus_in  input  16  CPU data bus, sampled for instruction register load.
- II  input  1  instruction-register load, active-high, decoded from the current uinstr.
- RT  input  1  T-state reset, active-high, decoded from the current uinstr.
- stall  input  1  memory/IO wait; freezes all sequencer state.
- rom_data  input  16  microcode ROM word at rom_addr (asynchronous ROM).
- rom_addr  output  11  microcode address {IR[15:8], tstate[2:0]}.
- uinstr  output  16  microinstruction to control decode; bit 15 is EO_bar, bits 14:0 are as the control decode expects.
- tstate  output  3  current T-state.
- fetching  output  1  high when tstate is 0 or 1.
- overrun  output  1  sticky flag: an instruction ran past T7 without RT.
REQ-002 The block SHALL use a single clock, clk; reset SHALL be synchronous and active-high on port reset.
REQ-003 The block SHALL have the following parameters, one per line: name, default, meaning.
- FETCH0  16'h8060  hardwired T0 word (PO, MI; EO off).
- FETCH1  16'hB440  hardwired T1 word (MO, II, P+; EO off).
- NOP  16'h8000  word driven during reset (no input enabled, EO off).

Function
REQ-004 State SHALL be: IR[15:0], tstate[2:0], overrun.
REQ-005 uinstr SHALL be combinational:
- NOP while reset is high.
- Otherwise FETCH0 when tstate==0, FETCH1 when tstate==1, and rom_data when tstate is 2 through 7.
REQ-006 rom_addr SHALL be {IR[15:8], tstate} at all times, including during fetch T-states.
REQ-007 fetching SHALL equal (tstate==0 || tstate==1), combinationally.
REQ-008 On each rising edge, when reset is low and stall is low:
- If RT is high, tstate SHALL become 0.
- Else tstate SHALL increment, wrapping from 7 to 0.
REQ-009 On a rising edge where reset is low, stall is low and II is high, IR SHALL load bus_in, independent of RT.
REQ-010 On a rising edge where reset is low and stall is high, IR, tstate and overrun SHALL all hold; II and RT SHALL be ignored on that edge.
REQ-011 On a rising edge where reset is low, stall is low, tstate==7 and RT is low, the wrap to 0 SHALL occur and overrun SHALL set to 1.
REQ-012 overrun SHALL be sticky; only reset SHALL clear it.
REQ-013 Simultaneous events SHALL resolve by priority: reset, then stall, then RT, then increment.
REQ-014 RT asserted during T0 or T1 SHALL still return tstate to 0 on the next edge, without setting overrun.
REQ-015 Latency: a new uinstr SHALL be presented in the same cycle the tstate changes; there SHALL be no registered output stage.

Reset
REQ-016 With reset high at a rising edge, the block SHALL set IR=16'h0000, tstate=0 and overrun=0, regardless of stall, II and RT.
REQ-017 During reset, outputs SHALL read: uinstr=NOP, rom_addr=11'h000 after the edge, fetching=1 after the edge.
REQ-018 After reset deasserts, the first non-stalled cycle SHALL present FETCH0.
REQ-019 Reset asserted mid-instruction SHALL abandon the instruction; no partial IR load SHALL occur on the reset edge.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset then release, stall=0, RT=0 for 2 clocks -> uinstr 16'h8060 at T0, 16'hB440 at T1, tstate 0 -> 1 -> 2.
- bus_in=16'h1234 with II=1 at T1 -> IR=16'h1234; at T2 rom_addr=11'h092 and uinstr equals the rom_data driven.
- RT=1 at T4 -> next cycle tstate=0, uinstr=16'h8060, overrun=0.
- stall=1 for 3 cycles at T3 with II=1, RT=1 -> tstate stays 3, IR unchanged; resumes at T4 once stall drops.
- No RT through T7 -> tstate wraps to 0, overrun=1 and stays 1 across later RT cycles until reset.
- reset=1 at T5 together with stall=1 and II=1 -> tstate=0, IR=0, overrun=0; uinstr=16'h8000 while reset is high.
